// File: rtl/spmv_issue_controller_pkg.sv
// spmv_issue_controller_pkg
//   Shared definitions for the SpMV issue controller: default widths,
//   FIFO depth, flush length and the FSM state encoding.
//   The row sentinel is all-ones at whatever ROW_BITS the top is built with.
package spmv_issue_controller_pkg;

    localparam int ROW_BITS_DEF      = 16;
    localparam int COL_BITS_DEF      = 16;
    localparam int VAL_BITS_DEF      = 16;
    localparam int NNZ_BITS_DEF      = 16;
    localparam int FIFO_DEPTH_DEF    = 16;
    localparam int FLUSH_ENTRIES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/spmv_issue_controller_credit_counter.sv
// spmv_credit_counter
//   Up/down credit counter guarding the row-id and product FIFOs.
//   Starts at FIFO_DEPTH. One credit is taken per issued item and one is
//   returned per accumulator pop.
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   issue_i          an item is issued this cycle (consumes one credit)
//   pop_i            accumulator popped one entry (returns one credit)
//   credits_avail_o  at least one credit left
//   all_returned_o   every credit is home (both FIFOs empty, nothing in flight)
module spmv_credit_counter
    import spmv_issue_controller_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic issue_i,
    input  logic pop_i,
    output logic credits_avail_o,
    output logic all_returned_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [CW-1:0] credits_q, credits_d;
    logic          pop_ok;

    // A pop with every credit already home is a protocol error; drop it so
    // the counter saturates instead of wrapping past FIFO_DEPTH.
    assign pop_ok = pop_i && (credits_q != FULL);

    always_comb begin
        credits_d = credits_q - CW'(issue_i) + CW'(pop_ok);
    end

    always_ff @(posedge Clk) begin
        if (Reset) credits_q <= FULL;
        else       credits_q <= credits_d;
    end

    assign credits_avail_o = (credits_q != '0);
    assign all_returned_o  = (credits_q == FULL);

endmodule

// File: rtl/spmv_issue_controller.sv
// spmv_issue_controller
//   Front-end sequencer for the SpMV datapath. Walks the row-sorted COO entry
//   memory, fetches x[col], issues (val, x) to the multiplier and pushes the
//   row id into the row-id FIFO. Appends FLUSH_ENTRIES sentinel items so the
//   accumulator closes the last row, then waits for both FIFOs to drain.
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   start, nnz_count                job launch (sampled in IDLE only)
//   busy, done                      job status / one-cycle completion pulse
//   entry_rd_en/addr, entry_row/col/val   entry memory (1-cycle read)
//   vec_rd_en/addr, vec_data        vector memory (1-cycle read)
//   mul_valid, mul_a, mul_b         multiplier operands
//   row_wr_en, row_wr_data          row-id FIFO push
//   pop                             accumulator pop, returns one credit
// Pipeline: S0 entry read, S1 vector read, S2 issue. Memory read data is
// forwarded combinationally (vec_rd_addr from entry_col, mul_b from
// vec_data) so entry_rd_en -> mul_valid stays at exactly 2 cycles; those
// paths are gated to 0 when their stage is idle.
module spmv_issue_controller
    import spmv_issue_controller_pkg::*;
#(
    parameter int ROW_BITS      = ROW_BITS_DEF,
    parameter int COL_BITS      = COL_BITS_DEF,
    parameter int VAL_BITS      = VAL_BITS_DEF,
    parameter int NNZ_BITS      = NNZ_BITS_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int FLUSH_ENTRIES = FLUSH_ENTRIES_DEF
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [NNZ_BITS-1:0] nnz_count,
    output logic                busy,
    output logic                done,
    output logic                entry_rd_en,
    output logic [NNZ_BITS-1:0] entry_rd_addr,
    input  logic [ROW_BITS-1:0] entry_row,
    input  logic [COL_BITS-1:0] entry_col,
    input  logic [VAL_BITS-1:0] entry_val,
    output logic                vec_rd_en,
    output logic [COL_BITS-1:0] vec_rd_addr,
    input  logic [VAL_BITS-1:0] vec_data,
    output logic                mul_valid,
    output logic [VAL_BITS-1:0] mul_a,
    output logic [VAL_BITS-1:0] mul_b,
    output logic                row_wr_en,
    output logic [ROW_BITS-1:0] row_wr_data,
    input  logic                pop
);

    localparam int FW = $clog2(FLUSH_ENTRIES + 1);
    localparam logic [ROW_BITS-1:0] ROW_SENTINEL = '1;

    state_e              state_q;
    logic                busy_q, done_q;
    logic [NNZ_BITS-1:0] nnz_q, idx_q, rd_addr_q;
    logic [FW-1:0]       flush_cnt_q;
    // Stage n holds an item when vld_pipe_q[n]; sent_pipe_q[n] marks sentinels.
    logic [2:0]          vld_pipe_q, sent_pipe_q;
    logic [ROW_BITS-1:0] s2_row_q;
    logic [VAL_BITS-1:0] s2_val_q;

    logic credits_avail, all_returned;
    logic issue_real, issue_sent, issue;

    assign issue_real = (state_q == ST_ISSUE) && credits_avail;
    assign issue_sent = (state_q == ST_FLUSH) && credits_avail;
    assign issue      = issue_real || issue_sent;

    spmv_credit_counter #(.FIFO_DEPTH(FIFO_DEPTH)) u_credit (
        .Clk             (Clk),
        .Reset           (Reset),
        .issue_i         (issue),
        .pop_i           (pop),
        .credits_avail_o (credits_avail),
        .all_returned_o  (all_returned)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            nnz_q       <= '0;
            idx_q       <= '0;
            rd_addr_q   <= '0;
            flush_cnt_q <= '0;
            vld_pipe_q  <= '0;
            sent_pipe_q <= '0;
            s2_row_q    <= '0;
            s2_val_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            vld_pipe_q  <= {vld_pipe_q[1:0], issue};
            sent_pipe_q <= {sent_pipe_q[1:0], issue_sent};

            // S1 -> S2: capture row/val alongside the vector read
            if (vld_pipe_q[1]) begin
                s2_row_q <= sent_pipe_q[1] ? ROW_SENTINEL : entry_row;
                s2_val_q <= sent_pipe_q[1] ? '0 : entry_val;
            end

            case (state_q)
                ST_IDLE: if (start) begin
                    nnz_q   <= nnz_count;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= (nnz_count == '0) ? ST_DONE : ST_ISSUE;
                end
                ST_ISSUE: if (credits_avail) begin
                    rd_addr_q <= idx_q;
                    idx_q     <= idx_q + NNZ_BITS'(1);
                    if (idx_q == nnz_q - NNZ_BITS'(1)) begin
                        flush_cnt_q <= '0;
                        state_q     <= ST_FLUSH;
                    end
                end
                ST_FLUSH: if (credits_avail) begin
                    flush_cnt_q <= flush_cnt_q + FW'(1);
                    if (flush_cnt_q == FW'(FLUSH_ENTRIES - 1)) state_q <= ST_DRAIN;
                end
                ST_DRAIN: if (vld_pipe_q == '0 && all_returned) state_q <= ST_DONE;
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign entry_rd_en   = vld_pipe_q[0] & ~sent_pipe_q[0];
    assign entry_rd_addr = rd_addr_q;
    assign vec_rd_en     = vld_pipe_q[1] & ~sent_pipe_q[1];
    assign vec_rd_addr   = vec_rd_en ? entry_col : '0;
    assign mul_valid     = vld_pipe_q[2];
    assign mul_a         = s2_val_q;
    assign mul_b         = (vld_pipe_q[2] & ~sent_pipe_q[2]) ? vec_data : '0;
    assign row_wr_en     = vld_pipe_q[2];
    assign row_wr_data   = s2_row_q;

endmodule
